// File: rtl/logic_unit_pipe.sv
// Pipelined paired bitwise logic unit with accumulator chaining and a DEPTH-entry result FIFO.
// Define LOGIC_UNIT_PIPE_FLAGS_EN to add per-entry zero/all-ones flags on the head (out_zero, out_ones).
module logic_unit_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   logic_in,
  input  logic [1:0]           logic_lines,
  input  logic                 chain,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   logic_out,
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  output logic                 out_zero,
  output logic                 out_ones,
`endif
  output logic [15:0]          op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   op1, op2, primary, secondary;
  logic               push, pop;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign logic_out = mem[rd_ptr];

  assign op1 = logic_in[2*WIDTH-1:WIDTH];
  assign op2 = chain ? acc : logic_in[WIDTH-1:0];

  always_comb begin
    primary   = '0;
    secondary = '0;
    case (logic_lines)
      2'd0: begin primary = op1 & op2; secondary = ~(op1 & op2); end
      2'd1: begin primary = op1 | op2; secondary = ~(op1 | op2); end
      2'd2: begin primary = op1 ^ op2; secondary = ~(op1 ^ op2); end
      default: begin primary = ~op1; secondary = ~op2; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      acc      <= '0;
      op_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {primary, secondary};
        wr_ptr      <= wr_ptr + 1'b1;
        acc         <= primary;
        op_count    <= op_count + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  // Flags are computed at accept and stored alongside the entry they describe.
  logic [1:0] flag_mem [DEPTH];

  assign out_zero = flag_mem[rd_ptr][1];
  assign out_ones = flag_mem[rd_ptr][0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) flag_mem[i] <= '0;
    end else if (push) begin
      flag_mem[wr_ptr] <= {(primary == '0), (&primary)};
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=16, DEPTH=4).
module tb_logic_unit_pipe;
  logic        clk = 0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] logic_in;
  logic [1:0]  logic_lines;
  logic        chain;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] logic_out;
  logic [15:0] op_count;
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  logic        out_zero, out_ones;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic_unit_pipe #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .logic_in(logic_in), .logic_lines(logic_lines), .chain(chain),
    .out_valid(out_valid), .out_ready(out_ready), .logic_out(logic_out),
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    .out_zero(out_zero), .out_ones(out_ones),
`endif
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic drive_beat(input logic v, input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] s, input logic c);
    in_valid = v; logic_in = {a, b}; logic_lines = s; chain = c;
  endtask

  task automatic test_reset;
    rst_n = 0; out_ready = 0;
    drive_beat(1'b0, 16'h0, 16'h0, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (op_count !== 16'd0) begin n_bad++; $display("FAIL reset_op_count got %0d want 0", op_count); end
    n_cmp++; if (logic_out !== 32'h0) begin n_bad++; $display("FAIL reset_logic_out got %h want 0", logic_out); end
    rst_n = 1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_ops;
    logic [31:0] exp_v [4];
    exp_v[0] = {16'hF000, 16'h0FFF};
    exp_v[1] = {16'hFFF0, 16'h000F};
    exp_v[2] = {16'h0FF0, 16'hF00F};
    exp_v[3] = {16'h0F0F, 16'h00FF};
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ops_valid sel%0d got %b want 1", i-1, out_valid); end
        n_cmp++; if (logic_out !== exp_v[i-1]) begin n_bad++; $display("FAIL ops_data sel%0d got %h want %h", i-1, logic_out, exp_v[i-1]); end
      end
      if (i < 4) drive_beat(1'b1, 16'hF0F0, 16'hFF00, 2'(i), 1'b0);
      else       drive_beat(1'b0, 16'h0, 16'h0, 2'd0, 1'b0);
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ops_drained got %b want 0", out_valid); end
    n_cmp++; if (op_count !== 16'd4) begin n_bad++; $display("FAIL ops_count got %0d want 4", op_count); end
  endtask

  task automatic test_chain;
    out_ready = 1;
    drive_beat(1'b1, 16'hF0F0, 16'hFF00, 2'd0, 1'b0);
    @(negedge clk);
    n_cmp++; if (logic_out !== {16'hF000, 16'h0FFF}) begin n_bad++; $display("FAIL chain_b1 got %h want f0000fff", logic_out); end
    drive_beat(1'b1, 16'h00FF, 16'h1234, 2'd2, 1'b1);
    @(negedge clk);
    n_cmp++; if (logic_out !== {16'hF0FF, 16'h0F00}) begin n_bad++; $display("FAIL chain_b2 got %h want f0ff0f00", logic_out); end
    drive_beat(1'b1, 16'h0000, 16'h5555, 2'd1, 1'b1);
    @(negedge clk);
    n_cmp++; if (logic_out !== {16'hF0FF, 16'h0F00}) begin n_bad++; $display("FAIL chain_acc got %h want f0ff0f00", logic_out); end
    drive_beat(1'b0, 16'h0, 16'h0, 2'd0, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || op_count !== 16'd7) begin n_bad++; $display("FAIL chain_end got valid=%b count=%0d want 0/7", out_valid, op_count); end
  endtask

  task automatic test_full;
    out_ready = 0;
    for (int t = 0; t < 4; t++) begin
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_fill_ready%0d got %b want 1", t, in_ready); end
      drive_beat(1'b1, 16'hFFFF, 16'(t + 1), 2'd0, 1'b0);
      @(negedge clk);
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_low got %b want 0", in_ready); end
    drive_beat(1'b1, 16'hFFFF, 16'd5, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_held got %b want 0", in_ready); end
    n_cmp++; if (logic_out !== {16'd1, ~16'd1}) begin n_bad++; $display("FAIL full_head0 got %h want %h", logic_out, {16'd1, ~16'd1}); end
    out_ready = 1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_after_pop got %b want 1", in_ready); end
    n_cmp++; if (logic_out !== {16'd2, ~16'd2}) begin n_bad++; $display("FAIL full_head1 got %h want %h", logic_out, {16'd2, ~16'd2}); end
    @(negedge clk);
    drive_beat(1'b0, 16'h0, 16'h0, 2'd0, 1'b0);
    for (int k = 3; k <= 5; k++) begin
      n_cmp++; if (logic_out !== {16'(k), ~16'(k)} || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL full_drain%0d got %h valid=%b want %h", k, logic_out, out_valid, {16'(k), ~16'(k)}); end
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL full_empty got %b want 0", out_valid); end
    n_cmp++; if (op_count !== 16'd12) begin n_bad++; $display("FAIL full_count got %0d want 12", op_count); end
  endtask

  task automatic test_back_to_back;
    out_ready = 0;
    drive_beat(1'b1, 16'hFFFF, 16'h0100, 2'd0, 1'b0);
    @(negedge clk);
    drive_beat(1'b1, 16'hFFFF, 16'h0101, 2'd0, 1'b0);
    @(negedge clk);
    n_cmp++; if (op_count !== 16'd14) begin n_bad++; $display("FAIL b2b_start_count got %0d want 14", op_count); end
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (logic_out !== {16'h0100 + 16'(i), ~(16'h0100 + 16'(i))} || in_ready !== 1'b1) begin
        n_bad++; $display("FAIL b2b_head%0d got %h ready=%b want %h", i, logic_out, in_ready, {16'h0100 + 16'(i), ~(16'h0100 + 16'(i))}); end
      drive_beat(1'b1, 16'hFFFF, 16'h0102 + 16'(i), 2'd0, 1'b0);
      @(negedge clk);
    end
    drive_beat(1'b0, 16'h0, 16'h0, 2'd0, 1'b0);
    n_cmp++; if (op_count !== 16'd24) begin n_bad++; $display("FAIL b2b_count got %0d want 24", op_count); end
    n_cmp++; if (logic_out !== {16'h010A, ~16'h010A}) begin n_bad++; $display("FAIL b2b_tail0 got %h want %h", logic_out, {16'h010A, ~16'h010A}); end
    @(negedge clk);
    n_cmp++; if (logic_out !== {16'h010B, ~16'h010B} || out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_tail1 got %h valid=%b want %h", logic_out, out_valid, {16'h010B, ~16'h010B}); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 0;
    drive_beat(1'b1, 16'hAAAA, 16'h5555, 2'd2, 1'b0);
    @(negedge clk);
    drive_beat(1'b1, 16'h1111, 16'h2222, 2'd1, 1'b0);
    @(negedge clk);
    drive_beat(1'b1, 16'h1234, 16'h0000, 2'd1, 1'b0);
    @(negedge clk);
    rst_n = 0;
    drive_beat(1'b1, 16'hFFFF, 16'hFFFF, 2'd0, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_hs got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    n_cmp++; if (op_count !== 16'd0) begin n_bad++; $display("FAIL midrst_count got %0d want 0", op_count); end
    n_cmp++; if (logic_out !== 32'h0) begin n_bad++; $display("FAIL midrst_data got %h want 0", logic_out); end
    rst_n = 1;
    drive_beat(1'b0, 16'h0, 16'h0, 2'd0, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_dropped got %b want 0", out_valid); end
    drive_beat(1'b1, 16'h0000, 16'hABCD, 2'd1, 1'b1);
    @(negedge clk);
    drive_beat(1'b0, 16'h0, 16'h0, 2'd0, 1'b0);
    n_cmp++; if (logic_out !== {16'h0000, 16'hFFFF} || out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_acc got %h valid=%b want 0000ffff", logic_out, out_valid); end
    n_cmp++; if (op_count !== 16'd1) begin n_bad++; $display("FAIL midrst_count1 got %0d want 1", op_count); end
    out_ready = 1;
    @(negedge clk);
  endtask

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  task automatic test_flags;
    out_ready = 1;
    drive_beat(1'b1, 16'h0000, 16'hFFFF, 2'd0, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_zero !== 1'b1 || out_ones !== 1'b0) begin n_bad++; $display("FAIL flags_zero got z=%b o=%b want 1/0", out_zero, out_ones); end
    drive_beat(1'b1, 16'h0000, 16'h1234, 2'd3, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_zero !== 1'b0 || out_ones !== 1'b1) begin n_bad++; $display("FAIL flags_ones got z=%b o=%b want 0/1", out_zero, out_ones); end
    drive_beat(1'b0, 16'h0, 16'h0, 2'd0, 1'b0);
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset;
    test_ops;
    test_chain;
    test_full;
    test_back_to_back;
    test_reset_mid;
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    test_flags;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
